// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory
// and queues returned words in order for the IF/ID latch.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inscode,
  output logic        insvalid,
  output logic [31:0] pc_out
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   QD_FULL = (CW + 1)'(QDEPTH);
  localparam logic [CW-1:0] C_ONE   = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] P_ONE   = {{(PW - 1){1'b0}}, 1'b1};

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_last_pc;

  logic [PW-1:0] r_q_head;
  logic [PW-1:0] r_q_tail;
  logic [31:0]   r_q_data [QDEPTH];
  logic [31:0]   r_q_addr [QDEPTH];

  // Addresses of granted requests, popped as their responses come back.
  logic [PW-1:0] r_af_head;
  logic [PW-1:0] r_af_tail;
  logic [31:0]   r_af_addr [QDEPTH];

  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_grant;
  logic          w_resp;
  logic          w_discard;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_count_next;

  assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit   = (w_inflight < QD_FULL);

  assign imem_req  = !rst && !redirect && w_credit;
  assign imem_addr = r_pc;

  assign w_grant   = imem_req && imem_gnt;
  // A response with nothing outstanding cannot be matched to an address.
  assign w_resp    = imem_rvalid && (r_outstanding != '0);
  assign w_discard = w_resp && (r_drop != '0);
  assign w_push    = w_resp && (r_drop == '0) && !redirect;
  assign w_pop     = (r_count != '0) && !stall && !redirect;

  assign insvalid = (r_count != '0);
  assign inscode  = insvalid ? r_q_data[r_q_head] : NOP;
  assign pc_out   = insvalid ? r_q_addr[r_q_head] : r_last_pc;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_grant && !w_resp) begin
      w_out_next = r_outstanding + C_ONE;
    end else if (!w_grant && w_resp) begin
      w_out_next = r_outstanding - C_ONE;
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + C_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_last_pc     <= '0;
      r_q_head      <= '0;
      r_q_tail      <= '0;
      r_af_head     <= '0;
      r_af_tail     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_count       <= w_count_next;
      if (insvalid) begin
        r_last_pc <= r_q_addr[r_q_head];
      end
      if (w_grant) begin
        r_af_tail <= r_af_tail + P_ONE;
      end
      if (w_resp) begin
        r_af_head <= r_af_head + P_ONE;
      end
      if (redirect) begin
        // Everything still outstanding after this edge belongs to the old path.
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_drop   <= w_out_next;
        r_q_head <= '0;
        r_q_tail <= '0;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_discard) begin
          r_drop <= r_drop - C_ONE;
        end
        if (w_push) begin
          r_q_tail <= r_q_tail + P_ONE;
        end
        if (w_pop) begin
          r_q_head <= r_q_head + P_ONE;
        end
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_af_addr[r_af_tail] <= r_pc;
    end
    if (w_push) begin
      r_q_data[r_q_tail] <= imem_rdata;
      r_q_addr[r_q_tail] <= r_af_addr[r_af_head];
    end
  end

  a_resp_tracked: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (r_outstanding != '0));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    w_inflight <= QD_FULL);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: addr-as-data memory with selectable 1- or 3-cycle
// response latency, walking through free run, stall, redirect, PC wrap and reset.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inscode;
  logic        insvalid;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  // Memory model: grant-to-rvalid delay selected by tap (0 -> 1 cycle, 2 -> 3 cycles).
  logic        pv [3];
  logic [31:0] pa [3];
  logic [1:0]  tap;

  ifetch #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (4),
    .NOP     (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inscode    (inscode),
    .insvalid   (insvalid),
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= 32'h0;
      end
    end else begin
      pv[0] <= imem_req && imem_gnt;
      pa[0] <= imem_addr;
      pv[1] <= pv[0];
      pa[1] <= pa[0];
      pv[2] <= pv[1];
      pa[2] <= pa[1];
    end
  end

  assign imem_rvalid = pv[tap];
  assign imem_rdata  = pa[tap];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b1;
    tap         = 2'd0;

    // Reset, then free run with 1-cycle memory latency.
    tick();
    tick();
    chk1 ("rst_insvalid", insvalid, 1'b0);
    chk32("rst_inscode", inscode, 32'h0);
    chk32("rst_pc_out", pc_out, 32'h0);
    chk1 ("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk1 ("run_req0", imem_req, 1'b1);
    chk32("run_addr0", imem_addr, 32'h0);
    tick();
    chk1 ("run_fill_insvalid", insvalid, 1'b0);
    chk32("run_addr4", imem_addr, 32'h4);
    tick();
    chk1 ("run_insvalid0", insvalid, 1'b1);
    chk32("run_inscode0", inscode, 32'h0);
    chk32("run_pc_out0", pc_out, 32'h0);
    chk32("run_addr8", imem_addr, 32'h8);
    tick();
    chk1 ("run_insvalid4", insvalid, 1'b1);
    chk32("run_inscode4", inscode, 32'h4);
    chk32("run_pc_out4", pc_out, 32'h4);
    tick();
    chk1 ("run_insvalid8", insvalid, 1'b1);
    chk32("run_inscode8", inscode, 32'h8);
    chk32("run_pc_out8", pc_out, 32'h8);

    // Stall for five edges with 0x8 at the head; credits run out at count+outstanding=QDEPTH.
    stall = 1'b1;
    tick();
    chk32("stall_hold_1", inscode, 32'h8);
    chk1 ("stall_req_1", imem_req, 1'b1);
    tick();
    chk32("stall_hold_2", inscode, 32'h8);
    chk1 ("stall_req_2", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk32("stall_hold_n", inscode, 32'h8);
      chk1 ("stall_req_n", imem_req, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk32("release_inscode_c", inscode, 32'hC);
    chk1 ("release_insvalid_c", insvalid, 1'b1);
    tick();
    chk32("release_inscode_10", inscode, 32'h10);
    chk32("release_pc_out_10", pc_out, 32'h10);
    tick();
    chk32("release_inscode_14", inscode, 32'h14);

    // Redirect with two responses in flight, 3-cycle memory latency.
    rst = 1'b1;
    tick();
    tick();
    tap = 2'd2;
    rst = 1'b0;
    tick();
    tick();
    chk1("redir_pre_insvalid", insvalid, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0101;
    #1;
    chk1("redir_req_forced", imem_req, 1'b0);
    tick();
    chk1("redir_insvalid_0", insvalid, 1'b0);
    redirect = 1'b0;
    #1;
    chk1 ("redir_req_target", imem_req, 1'b1);
    chk32("redir_addr_target", imem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("redir_no_stale", insvalid, 1'b0);
    end
    tick();
    chk1 ("redir_first_valid", insvalid, 1'b1);
    chk32("redir_first_inscode", inscode, 32'h100);
    chk32("redir_first_pc_out", pc_out, 32'h100);
    tick();
    chk32("redir_second_inscode", inscode, 32'h104);
    chk32("redir_second_pc_out", pc_out, 32'h104);

    // Redirect coinciding with a response while the head is stalled.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    chk1 ("flush_insvalid", insvalid, 1'b0);
    chk32("flush_inscode", inscode, 32'h0);
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    chk1 ("flush_req", imem_req, 1'b1);
    chk32("flush_addr", imem_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("flush_no_stale", insvalid, 1'b0);
    end
    tick();
    chk1 ("flush_resume_valid", insvalid, 1'b1);
    chk32("flush_resume_inscode", inscode, 32'h200);
    chk32("flush_resume_pc_out", pc_out, 32'h200);

    // PC wrap past the top of the address space.
    rst = 1'b1;
    tick();
    tick();
    tap         = 2'd0;
    rst         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk1("wrap_req_forced", imem_req, 1'b0);
    tick();
    redirect = 1'b0;
    #1;
    chk1 ("wrap_req", imem_req, 1'b1);
    chk32("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    stall = 1'b1;
    tick();
    chk32("wrap_addr_zero", imem_addr, 32'h0);
    tick();
    chk1 ("wrap_insvalid", insvalid, 1'b1);
    chk32("wrap_inscode", inscode, 32'hFFFF_FFFC);
    chk32("wrap_pc_out", pc_out, 32'hFFFF_FFFC);

    // Fill the queue under stall, then reset mid-stream.
    tick();
    tick();
    tick();
    chk1 ("full_req", imem_req, 1'b0);
    chk32("full_head", inscode, 32'hFFFF_FFFC);
    rst = 1'b1;
    tick();
    chk1 ("mid_rst_insvalid", insvalid, 1'b0);
    chk32("mid_rst_inscode", inscode, 32'h0);
    chk32("mid_rst_pc_out", pc_out, 32'h0);
    chk32("mid_rst_addr", imem_addr, 32'h0);
    rst   = 1'b0;
    stall = 1'b0;
    #1;
    chk1("mid_rst_req_after", imem_req, 1'b1);
    tick();
    tick();
    chk1 ("mid_rst_refetch_valid", insvalid, 1'b1);
    chk32("mid_rst_refetch_pc", pc_out, 32'h0);
    chk32("mid_rst_refetch_addr", imem_addr, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
